dmem_image_tx: RTL and testbench

Reads a captured 28x28 grayscale frame back out of the 256-bit data memory and streams it byte-by-byte to the SPART transmitter. It is the read-side counterpart to the capture FSM's DMEM write port, which packs 16 pixels per word as 16-bit lanes holding {8'h00, pixel}. Each transfer sends a framed packet: header byte, 784 pixel bytes, then an 8-bit checksum, so the host can dump the camera image.

---
 rtl/ipsm_pkg.sv | 37 +++
 rtl/dmem_image_tx.sv | 176 +++++++++++++++++
 tb/tb_dmem_image_tx.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ipsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ipsm_pkg
//  Description : Shared definitions for the image-capture / SPART path:
//                DMEM transmit FSM state encoding, frame geometry and the
//                lane layout used by both the capture and readback blocks.
//                Each 256-bit DMEM word carries 16 pixels as 16-bit lanes
//                holding {8'h00, pixel}.
//  Revision    : 1.0 - initial release
// ============================================================================
package ipsm_pkg;

    // State encoding for the DMEM-to-SPART image transmitter
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_FETCH = 3'd2,
        ST_LOAD  = 3'd3,
        ST_PIX   = 3'd4,
        ST_SUM   = 3'd5,
        ST_DONE  = 3'd6
    } dmem_tx_state_t;

    localparam int         IMG_PIXELS   = 784;   // 28 x 28 frame
    localparam int         PIX_PER_WORD = 16;    // pixels per 256-bit word
    localparam int         LANE_W       = 16;    // bits per pixel lane
    localparam logic [7:0] SPART_HDR    = 8'hA5; // packet start byte

    // Pixel byte of a given lane; the lane's upper byte is padding and is
    // never returned. The {lane, 4'd0} index relies on LANE_W being 16.
    function automatic logic [7:0] lane_pixel(input logic [255:0] word,
                                              input logic [3:0]   lane);
        return word[{lane, 4'd0} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_image_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_image_tx
//  Description : Reads a captured 28x28 grayscale frame out of the 256-bit
//                DMEM and streams it to the SPART transmitter as a packet:
//                header byte, 784 pixel bytes, 8-bit checksum (mod-256 sum
//                of the pixel bytes only).
//  Ports       : iCLK          - clock (capture FSM pixel-clock domain)
//                iRST          - synchronous active-high reset
//                iSTART        - single-cycle frame send request
//                oBUSY         - frame in progress
//                oDONE         - one-cycle pulse after checksum accepted
//                oDmem_rden    - DMEM read strobe
//                oDmem_addr    - DMEM word address
//                iDmem_rddata  - DMEM read data (one cycle after rden)
//                oTX_DATA      - byte to SPART
//                oTX_VALID     - oTX_DATA valid
//                iTX_READY     - SPART can accept a byte
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_image_tx
    import ipsm_pkg::*;
#(
    parameter logic [6:0] BASE_ADDR = 7'd0,
    parameter int         NUM_WORDS = IMG_PIXELS / PIX_PER_WORD,
    parameter logic [7:0] HDR_BYTE  = SPART_HDR
) (
    input  logic         iCLK,
    input  logic         iRST,
    input  logic         iSTART,
    output logic         oBUSY,
    output logic         oDONE,
    output logic         oDmem_rden,
    output logic [6:0]   oDmem_addr,
    input  logic [255:0] iDmem_rddata,
    output logic [7:0]   oTX_DATA,
    output logic         oTX_VALID,
    input  logic         iTX_READY
);

    localparam logic [5:0] c_LAST_WORD = 6'(NUM_WORDS - 1);
    localparam logic [3:0] c_LAST_LANE = 4'(PIX_PER_WORD - 1);

    dmem_tx_state_t r_state;
    logic [5:0]     r_word_cnt;
    logic [3:0]     r_lane;
    logic [255:0]   r_word;
    logic [7:0]     r_sum;

    logic           r_busy;
    logic           r_done;
    logic           r_rden;
    logic [6:0]     r_addr;
    logic [7:0]     r_data;
    logic           r_valid;

    logic           w_accept;
    logic [3:0]     w_lane_nx;
    logic [5:0]     w_word_nx;
    logic [7:0]     w_sum_nx;

    assign w_accept  = r_valid && iTX_READY;
    assign w_lane_nx = r_lane + 4'd1;
    assign w_word_nx = r_word_cnt + 6'd1;
    assign w_sum_nx  = r_sum + r_data;

    // All outputs are registered: each state transition loads the values the
    // next state presents, so oTX_DATA only changes on an accepted byte.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state    <= ST_IDLE;
            r_word_cnt <= 6'd0;
            r_lane     <= 4'd0;
            r_word     <= '0;
            r_sum      <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rden     <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (iSTART) begin
                        r_state <= ST_HDR;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b1;
                        r_data  <= HDR_BYTE;
                    end
                end

                ST_HDR: begin
                    if (w_accept) begin
                        r_word_cnt <= 6'd0;
                        r_sum      <= 8'h00;
                        r_valid    <= 1'b0;
                        r_rden     <= 1'b1;
                        r_addr     <= BASE_ADDR;
                        r_state    <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    // Read strobe lasts exactly this one cycle
                    r_rden  <= 1'b0;
                    r_state <= ST_LOAD;
                end

                ST_LOAD: begin
                    r_word  <= iDmem_rddata;
                    r_lane  <= 4'd0;
                    r_data  <= lane_pixel(iDmem_rddata, 4'd0);
                    r_valid <= 1'b1;
                    r_state <= ST_PIX;
                end

                ST_PIX: begin
                    if (w_accept) begin
                        r_sum  <= w_sum_nx;
                        r_lane <= w_lane_nx;
                        if (r_lane == c_LAST_LANE) begin
                            if (r_word_cnt == c_LAST_WORD) begin
                                // Checksum goes out directly; VALID stays high
                                r_data  <= w_sum_nx;
                                r_state <= ST_SUM;
                            end else begin
                                r_word_cnt <= w_word_nx;
                                r_valid    <= 1'b0;
                                r_rden     <= 1'b1;
                                r_addr     <= BASE_ADDR + {1'b0, w_word_nx};
                                r_state    <= ST_FETCH;
                            end
                        end else begin
                            r_data <= lane_pixel(r_word, w_lane_nx);
                        end
                    end
                end

                ST_SUM: begin
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        r_data  <= 8'h00;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // iSTART is deliberately not looked at here
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_rden  <= 1'b0;
                    r_valid <= 1'b0;
                    r_data  <= 8'h00;
                end
            endcase
        end
    end

    assign oBUSY      = r_busy;
    assign oDONE      = r_done;
    assign oDmem_rden = r_rden;
    assign oDmem_addr = r_addr;
    assign oTX_DATA   = r_data;
    assign oTX_VALID  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_dmem_image_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_image_tx
//  Description : Directed self-checking bench for dmem_image_tx. Two
//                instances (BASE_ADDR 0 and 64) read the same DMEM model
//                and share the SPART handshake; received streams are
//                compared against a bench-side frame model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_image_tx;
    import ipsm_pkg::*;

    localparam int NW = 49;
    localparam int FRAME_BYTES = 786;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         ready = 1'b0;
    int           rdy_pct = 100;

    logic [1:0]   busy, done, rden, valid;
    logic [6:0]   addr   [2];
    logic [7:0]   txd    [2];
    logic [255:0] rddata [2];
    logic [255:0] mem    [128];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_image_tx #(.BASE_ADDR(7'd0)) dut0 (
        .iCLK(clk), .iRST(rst), .iSTART(start),
        .oBUSY(busy[0]), .oDONE(done[0]),
        .oDmem_rden(rden[0]), .oDmem_addr(addr[0]), .iDmem_rddata(rddata[0]),
        .oTX_DATA(txd[0]), .oTX_VALID(valid[0]), .iTX_READY(ready)
    );

    dmem_image_tx #(.BASE_ADDR(7'd64)) dut1 (
        .iCLK(clk), .iRST(rst), .iSTART(start),
        .oBUSY(busy[1]), .oDONE(done[1]),
        .oDmem_rden(rden[1]), .oDmem_addr(addr[1]), .iDmem_rddata(rddata[1]),
        .oTX_DATA(txd[1]), .oTX_VALID(valid[1]), .iTX_READY(ready)
    );

    // DMEM: read data valid the cycle after the strobe
    always @(posedge clk) begin
        if (rden[0]) rddata[0] <= mem[addr[0]];
        if (rden[1]) rddata[1] <= mem[addr[1]];
    end

    // SPART ready, re-drawn every cycle at the requested duty
    initial begin
        forever begin
            @(posedge clk);
            #1 ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // Per-instance receive monitor
    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam logic [6:0] MBASE = (g == 0) ? 7'd0 : 7'd64;
        logic [7:0] rxb [0:8191];
        int   rxn = 0, ndone = 0, nrden = 0, widx = 0;
        int   addr_err = 0, hs_err = 0, pulse_err = 0;
        logic p_stall = 1'b0, p_rden = 1'b0, p_busy = 1'b0;
        logic [7:0] p_data = 8'h00;

        always @(negedge clk) begin
            if (rst) begin
                p_stall <= 1'b0;
                p_rden  <= 1'b0;
                p_busy  <= 1'b0;
            end else begin
                if (p_stall && (!valid[g] || txd[g] !== p_data))
                    hs_err <= hs_err + 1;
                if (valid[g] && ready) begin
                    rxb[rxn] <= txd[g];
                    rxn      <= rxn + 1;
                end
                if (done[g]) ndone <= ndone + 1;
                if (rden[g]) begin
                    nrden <= nrden + 1;
                    if (p_rden) pulse_err <= pulse_err + 1;
                    if (addr[g] !== MBASE + 7'(widx)) addr_err <= addr_err + 1;
                end
                if (busy[g] && !p_busy) widx <= 0;
                else if (rden[g])       widx <= widx + 1;
                p_stall <= valid[g] && !ready;
                p_data  <= txd[g];
                p_rden  <= rden[g];
                p_busy  <= busy[g];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ramp: pixel p = p mod 256 with lane high bytes FF; otherwise all zero.
    // Unused words hold EE so a wrong address shows up in the stream.
    task automatic fill_mem(input bit ramp_i);
        logic [7:0] px;
        for (int a = 0; a < 128; a++) mem[a] = {32{8'hEE}};
        for (int w = 0; w < NW; w++) begin
            for (int l = 0; l < 16; l++) begin
                px = ramp_i ? 8'(w * 16 + l) : 8'h00;
                mem[w][16*l +: 16]      = {(ramp_i ? 8'hFF : 8'h00), px};
                mem[64 + w][16*l +: 16] = {(ramp_i ? 8'hFF : 8'h00), px};
            end
        end
    endtask

    task automatic check_stream(input int g, input int base, input bit ramp_i, input string tag);
        int n, errs;
        logic [7:0] sum, e, got;
        n = ((g == 0) ? g_mon[0].rxn : g_mon[1].rxn) - base;
        chk({tag, "_len"}, n, FRAME_BYTES);
        errs = 0;
        sum  = 8'h00;
        for (int k = 0; k < FRAME_BYTES && k < n; k++) begin
            if (k == 0)                    e = 8'hA5;
            else if (k == FRAME_BYTES - 1) e = sum;
            else begin
                e   = ramp_i ? 8'(k - 1) : 8'h00;
                sum = sum + e;
            end
            got = (g == 0) ? g_mon[0].rxb[base + k] : g_mon[1].rxb[base + k];
            if (got !== e) errs++;
        end
        chk({tag, "_bytes"}, errs, 0);
    endtask

    // Pulse iSTART for the cycle in progress, then check the header at t+1
    task automatic pulse_start_now(input string tag);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk({tag, "_hdr_busy"},  busy[0],  1);
        chk({tag, "_hdr_valid"}, valid[0], 1);
        chk({tag, "_hdr_data"},  txd[0],   8'hA5);
    endtask

    task automatic start_frame(input string tag);
        @(posedge clk);
        #1;
        pulse_start_now(tag);
    endtask

    // Called at the negedge of cycle t+1; returns with n = cycles after iSTART
    task automatic wait_done(input int budget, input string tag, output int n);
        n = 1;
        while (!done[0] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, done[0], 1);
        chk({tag, "_busy_at_done"}, busy[0], 0);
    endtask

    task automatic wait_bytes(input int base, input int nbytes);
        for (int i = 0; i < 20000 && (g_mon[0].rxn - base) < nbytes; i++)
            @(negedge clk);
    endtask

    initial begin
        int cyc;
        int b0, b1, d0, d1, r0, r1;

        fill_mem(1'b0);

        // ---- reset state ----
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  busy[0],  0);
        chk("rst_done",  done[0],  0);
        chk("rst_rden",  rden[0],  0);
        chk("rst_valid", valid[0], 0);
        chk("rst_data",  txd[0],   8'h00);
        chk("rst_addr0", addr[0],  7'd0);
        chk("rst_addr1", addr[1],  7'd64);
        @(posedge clk);
        #1 rst = 1'b0;

        // ---- all-zero frame, ready always high ----
        b0 = g_mon[0].rxn; b1 = g_mon[1].rxn;
        d0 = g_mon[0].ndone; d1 = g_mon[1].ndone;
        r0 = g_mon[0].nrden; r1 = g_mon[1].nrden;
        start_frame("zero");
        wait_done(3000, "zero", cyc);
        chk("zero_latency", cyc, 885);
        repeat (3) @(negedge clk);
        check_stream(0, b0, 1'b0, "zero_d0");
        check_stream(1, b1, 1'b0, "zero_d1");
        chk("zero_ndone0", g_mon[0].ndone - d0, 1);
        chk("zero_ndone1", g_mon[1].ndone - d1, 1);
        chk("zero_nrden0", g_mon[0].nrden - r0, NW);
        chk("zero_nrden1", g_mon[1].nrden - r1, NW);

        // ---- ramp frame, ready always high ----
        fill_mem(1'b1);
        b0 = g_mon[0].rxn; b1 = g_mon[1].rxn; d0 = g_mon[0].ndone;
        start_frame("ramp");
        wait_done(3000, "ramp", cyc);
        chk("ramp_latency", cyc, 885);
        repeat (3) @(negedge clk);
        check_stream(0, b0, 1'b1, "ramp_d0");
        check_stream(1, b1, 1'b1, "ramp_d1");
        chk("ramp_checksum", g_mon[0].rxb[b0 + FRAME_BYTES - 1], 8'hF8);
        chk("ramp_ndone", g_mon[0].ndone - d0, 1);

        // ---- ramp frame, ready at ~30% duty ----
        rdy_pct = 30;
        b0 = g_mon[0].rxn; b1 = g_mon[1].rxn;
        d0 = g_mon[0].ndone; r0 = g_mon[0].nrden;
        start_frame("rnd");
        wait_done(20000, "rnd", cyc);
        rdy_pct = 100;
        repeat (3) @(negedge clk);
        check_stream(0, b0, 1'b1, "rnd_d0");
        check_stream(1, b1, 1'b1, "rnd_d1");
        chk("rnd_ndone", g_mon[0].ndone - d0, 1);
        chk("rnd_nrden", g_mon[0].nrden - r0, NW);
        chk("rnd_hs0", g_mon[0].hs_err, 0);
        chk("rnd_hs1", g_mon[1].hs_err, 0);

        // ---- iSTART re-pulsed at byte 300 is ignored ----
        b0 = g_mon[0].rxn; d0 = g_mon[0].ndone;
        start_frame("rep");
        wait_bytes(b0, 300);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(3000, "rep", cyc);
        // iSTART during the DONE cycle must not start a frame
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("rep_start_in_done", busy[0], 0);
        check_stream(0, b0, 1'b1, "rep");
        chk("rep_ndone", g_mon[0].ndone - d0, 1);

        // ---- iSTART one cycle after DONE is accepted; reset at byte 100 ----
        b0 = g_mon[0].rxn; d0 = g_mon[0].ndone;
        pulse_start_now("b2b");
        wait_bytes(b0, 100);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy",  busy[0],  0);
        chk("abort_valid", valid[0], 0);
        chk("abort_data",  txd[0],   8'h00);
        chk("abort_rden",  rden[0],  0);
        chk("abort_addr",  addr[0],  7'd0);
        repeat (20) @(negedge clk);
        chk("abort_no_done", g_mon[0].ndone - d0, 0);

        // ---- fresh frame after abort ----
        b0 = g_mon[0].rxn; b1 = g_mon[1].rxn;
        d0 = g_mon[0].ndone; r0 = g_mon[0].nrden; r1 = g_mon[1].nrden;
        start_frame("post");
        wait_done(3000, "post", cyc);
        chk("post_latency", cyc, 885);
        repeat (3) @(negedge clk);
        check_stream(0, b0, 1'b1, "post_d0");
        check_stream(1, b1, 1'b1, "post_d1");
        chk("post_ndone", g_mon[0].ndone - d0, 1);
        chk("post_nrden0", g_mon[0].nrden - r0, NW);
        chk("post_nrden1", g_mon[1].nrden - r1, NW);

        // ---- DMEM access discipline over the whole run ----
        chk("addr_err0",  g_mon[0].addr_err,  0);
        chk("addr_err1",  g_mon[1].addr_err,  0);
        chk("pulse_err0", g_mon[0].pulse_err, 0);
        chk("pulse_err1", g_mon[1].pulse_err, 0);
        chk("hs_err_all", g_mon[0].hs_err,    0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
